// File: rtl/rom_byte_server.sv
// Byte-wide program memory serving a two-phase (toggle) request from fetch,
// with programmable wait states and a side load port for boot-time writes.
module rom_byte_server #(
    parameter int    DEPTH       = 1024,
    parameter int    WAIT_STATES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trigger_in,
    input  logic [31:0] addr_in,
    output logic [7:0]  data_out,
    output logic        ready_out,
    output logic        err_out,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [7:0]  ld_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    logic [7:0] mem [DEPTH];

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic        ack_q, ack_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [7:0]  data_q;
    logic        done;
    logic        in_range;
    logic        ld_ok;

    // Full 32-bit compares: addresses beyond DEPTH never alias into the array.
    assign in_range = (addr_q < 32'(DEPTH));
    assign ld_ok    = ld_en && (ld_addr < 32'(DEPTH));

    // Load port has no reset so memory contents survive rst_n.
    always_ff @(posedge clk) begin
        if (ld_ok) begin
            mem[ld_addr[AW-1:0]] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            ack_q   <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            sync1_q <= trigger_in;
            sync2_q <= sync1_q;
            ack_q   <= ack_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            // Registered read sees the pre-write byte on a same-cycle load.
            if (done) begin
                data_q <= in_range ? mem[addr_q[AW-1:0]] : 8'h00;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        req_d   = req_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync2_q != ack_q) begin
                    req_d   = sync2_q;
                    addr_d  = addr_in;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    done    = 1'b1;
                    ack_d   = req_q;
                    state_d = IDLE;
                    if (!in_range) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ready compares the raw trigger so it drops the instant fetch toggles.
    always_comb begin
        ready_out = ~(trigger_in ^ ack_q);
        data_out  = data_q;
        err_out   = err_q;
    end

endmodule

// File: tb/tb_rom_byte_server.sv
// Randomized scoreboard bench for rom_byte_server: a driver issues toggle
// requests and queues expected bytes, a monitor checks each ready rise.
module tb_rom_byte_server;

    localparam int DEPTH = 1024;
    localparam int W     = 2;

    logic        clk;
    logic        rst_n;
    logic        trigger_in;
    logic [31:0] addr_in;
    logic [7:0]  data_out;
    logic        ready_out;
    logic        err_out;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [7:0]  ld_data;

    rom_byte_server #(
        .DEPTH      (DEPTH),
        .WAIT_STATES(W),
        .INIT_FILE  ("")
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trigger_in(trigger_in),
        .addr_in   (addr_in),
        .data_out  (data_out),
        .ready_out (ready_out),
        .err_out   (err_out),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         done_cyc;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] model_mem [DEPTH];
    bit         model_err;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    bit         mon_en   = 1'b0;
    logic       rdy_prev = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every rising ready is one completed byte.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (mon_en && rst_n && ready_out && !rdy_prev) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ready", 32'(ready_out), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("data", 32'(data_out), 32'(e.data));
                check("err", 32'(err_out), 32'(e.err));
                check("latency_cyc", 32'(cyc), 32'(e.done_cyc));
                $display("txn: data=%02h err=%0d cyc=%0d", data_out, err_out, cyc);
            end
        end
        rdy_prev <= ready_out;
    end

    task automatic load(input logic [31:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
        if (a < DEPTH) model_mem[int'(a)] = d;
    endtask

    // One request; optional load-port write to the same address on the completing edge.
    task automatic request(input logic [31:0] a, input bit collide, input logic [7:0] nb);
        exp_t e;
        int   t;
        addr_in = a;
        @(negedge clk);
        if (a >= DEPTH) model_err = 1'b1;
        e.data     = (a < DEPTH) ? model_mem[int'(a)] : 8'h00;
        e.err      = model_err;
        e.done_cyc = cyc + 4 + W;
        sb_q.push_back(e);
        trigger_in = ~trigger_in;
        #1 check("ready_drop", 32'(ready_out), 32'd0);
        if (collide) begin
            repeat (3 + W) @(negedge clk);
            ld_en = 1'b1; ld_addr = a; ld_data = nb;
            @(negedge clk);
            ld_en = 1'b0;
            if (a < DEPTH) model_mem[int'(a)] = nb;
        end
        t = 0;
        while (!ready_out && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("ready_rise", 32'(ready_out), 32'd1);
        @(negedge clk);
    endtask

    // Request plus n_extra toggles during ACCESS; addr_in moves to b after acceptance.
    task automatic extra_toggle(input int n_extra, input logic [31:0] a, input logic [31:0] b,
                                input logic [7:0] exp_final);
        mon_en  = 1'b0;
        addr_in = a;
        @(negedge clk);
        trigger_in = ~trigger_in;
        repeat (3) @(negedge clk);
        addr_in = b;
        for (int k = 0; k < n_extra; k++) begin
            trigger_in = ~trigger_in;
            @(negedge clk);
        end
        repeat (15) @(negedge clk);
        check("xtog_ready", 32'(ready_out), 32'd1);
        check("xtog_data", 32'(data_out), 32'(exp_final));
        $display("txn: extra_toggles=%0d data=%02h ready=%0d", n_extra, data_out, ready_out);
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    initial begin
        logic [31:0] word;
        logic [31:0] a;
        int          t;

        rst_n = 1'b0; trigger_in = 1'b0; addr_in = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        model_err = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;

        repeat (2) @(negedge clk);
        check("rst_data", 32'(data_out), 32'h00);
        check("rst_err", 32'(err_out), 32'd0);
        check("rst_ready", 32'(ready_out), 32'd1);
        trigger_in = 1'b1;
        #1 check("rst_ready_drop", 32'(ready_out), 32'd0);
        trigger_in = 1'b0;
        #1 check("rst_ready_back", 32'(ready_out), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 64; i++) load(32'(i), 8'($urandom));
        mon_en = 1'b1;

        // Word fetch, little-endian byte order.
        load(0, 8'h0D); load(1, 8'hC0); load(2, 8'hA0); load(3, 8'hE1);
        word = '0;
        for (int i = 0; i < 4; i++) begin
            request(32'(i), 1'b0, 8'h00);
            word[8*i +: 8] = data_out;
        end
        check("word", word, 32'hE1A0C00D);

        // Out of range, then sticky error across a good request.
        request(32'h400, 1'b0, 8'h00);
        check("oor_data", 32'(data_out), 32'h00);
        check("oor_err", 32'(err_out), 32'd1);
        request(32'd4, 1'b0, 8'h00);
        check("err_sticky", 32'(err_out), 32'd1);

        // Same-cycle load collides with the read: old byte first, new byte next.
        load(8, 8'h11);
        request(32'd8, 1'b1, 8'h22);
        check("collide_old", 32'(data_out), 32'h11);
        request(32'd8, 1'b0, 8'h00);
        check("collide_new", 32'(data_out), 32'h22);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                a = ($urandom_range(0, 3) == 0) ? 32'h400 + $urandom_range(0, 63)
                                               : 32'($urandom_range(0, 63));
                load(a, 8'($urandom));
            end
            a = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h400) : 32'($urandom_range(0, 63));
            request(a, $urandom_range(0, 3) == 0, 8'($urandom));
        end

        load(10, 8'h5A); load(11, 8'hA5);
        extra_toggle(2, 32'd10, 32'd11, 8'h5A);
        extra_toggle(1, 32'd10, 32'd11, 8'hA5);

        // Reset mid-ACCESS with a high trigger pending.
        if (trigger_in) request(32'd5, 1'b0, 8'h00);
        load(12, 8'h3C);
        mon_en  = 1'b0;
        addr_in = 32'd12;
        @(negedge clk);
        trigger_in = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_data", 32'(data_out), 32'h00);
        check("midrst_err", 32'(err_out), 32'd0);
        check("midrst_ready", 32'(ready_out), 32'd0);
        model_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        while (!ready_out && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("midrst_latency", 32'(t), 32'(4 + W));
        check("midrst_reserve", 32'(data_out), 32'h3C);
        $display("txn: reset-mid-access reserve data=%02h edges=%0d", data_out, t);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
